// File: rtl/nn_pkg.sv
// Shared definitions for the NN coprocessor compute sequencer.
package nn_pkg;

    localparam int DATA_BITS      = 8;
    localparam int ROW_BITS       = 6;
    localparam int WT_ROW_BITS    = 3;
    localparam int RES_COL_BITS   = 3;
    localparam int NUM_ROWS_DEF   = 64;
    localparam int NUM_HIDDEN_DEF = 2;

    // Result RAM column map
    localparam logic [RES_COL_BITS-1:0] COL_H0  = 3'd0;
    localparam logic [RES_COL_BITS-1:0] COL_H1  = 3'd1;
    localparam logic [RES_COL_BITS-1:0] COL_OUT = 3'd2;

    // One-hot, same style as the top-level controller
    typedef enum logic [7:0] {
        ST_IDLE      = 8'h01,
        ST_FETCH     = 8'h02,
        ST_RD_WAIT   = 8'h04,
        ST_MAC_GO    = 8'h08,
        ST_MAC_WAIT  = 8'h10,
        ST_WRITEBACK = 8'h20,
        ST_NEXT      = 8'h40,
        ST_FINISH    = 8'h80
    } seq_state_t;

endpackage

// File: rtl/nn_compute_sequencer.sv
// Compute-phase sequencer: three MAC passes per dataset row (h0, h1, output),
// each activation written to the Result RAM.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | weight row (and data row for hidden passes) read issued
// RD_WAIT   | RAM read latency
// MAC_GO    | one-cycle MAC start pulse
// MAC_WAIT  | waiting for mac_done, result captured on it
// WRITEBACK | result written to Result RAM, hidden activation latched
// NEXT      | advance neuron / row or finish
// FINISH    | done pulse
module nn_compute_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_ROWS   = NUM_ROWS_DEF,
    parameter int NUM_HIDDEN = NUM_HIDDEN_DEF
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    data_rd_en,
    output logic [ROW_BITS-1:0]     data_rd_addr,
    output logic                    wt_rd_en,
    output logic [WT_ROW_BITS-1:0]  wt_rd_addr,
    output logic                    src_sel,
    output logic [DATA_BITS-1:0]    hid_out_0,
    output logic [DATA_BITS-1:0]    hid_out_1,
    output logic                    mac_start,
    input  logic                    mac_done,
    input  logic [DATA_BITS-1:0]    mac_result,
    output logic                    res_wr_en,
    output logic [ROW_BITS-1:0]     res_wr_depth,
    output logic [RES_COL_BITS-1:0] res_wr_col,
    output logic [DATA_BITS-1:0]    res_wr_data
);

    localparam logic [ROW_BITS-1:0]    ROW_LAST = ROW_BITS'(NUM_ROWS - 1);
    localparam logic [WT_ROW_BITS-1:0] HID_LAST = WT_ROW_BITS'(NUM_HIDDEN);

    seq_state_t            state_q, state_d;
    logic [ROW_BITS-1:0]   row_q;
    logic [WT_ROW_BITS-1:0] neuron_q;
    logic [DATA_BITS-1:0]  result_q;
    logic [DATA_BITS-1:0]  hid0_q, hid1_q;
    logic                  is_hidden;
    logic                  out_pass;

    assign is_hidden = (neuron_q < HID_LAST);
    assign out_pass  = (RES_COL_BITS'(neuron_q) == COL_OUT);

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and per-state strobes
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        wt_rd_en   = 1'b0;
        data_rd_en = 1'b0;
        mac_start  = 1'b0;
        res_wr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                busy       = 1'b1;
                wt_rd_en   = 1'b1;
                data_rd_en = is_hidden;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                busy    = 1'b1;
                state_d = ST_MAC_GO;
            end
            ST_MAC_GO: begin
                busy      = 1'b1;
                mac_start = 1'b1;
                state_d   = ST_MAC_WAIT;
            end
            ST_MAC_WAIT: begin
                busy = 1'b1;
                if (mac_done) state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                busy      = 1'b1;
                res_wr_en = 1'b1;
                state_d   = ST_NEXT;
            end
            ST_NEXT: begin
                busy = 1'b1;
                if (is_hidden || (row_q != ROW_LAST)) state_d = ST_FETCH;
                else                                  state_d = ST_FINISH;
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Row/neuron counters, captured MAC result and hidden activations
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            row_q    <= '0;
            neuron_q <= '0;
            result_q <= '0;
            hid0_q   <= '0;
            hid1_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        row_q    <= '0;
                        neuron_q <= '0;
                    end
                end
                ST_MAC_WAIT: begin
                    if (mac_done) result_q <= mac_result;
                end
                ST_WRITEBACK: begin
                    if (RES_COL_BITS'(neuron_q) == COL_H0) hid0_q <= result_q;
                    if (RES_COL_BITS'(neuron_q) == COL_H1) hid1_q <= result_q;
                end
                ST_NEXT: begin
                    if (is_hidden) begin
                        neuron_q <= neuron_q + 1'b1;
                    end else if (row_q != ROW_LAST) begin
                        row_q    <= row_q + 1'b1;
                        neuron_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The operand select follows the pass, gated off outside a run
    assign src_sel      = busy && out_pass;
    assign data_rd_addr = row_q;
    assign wt_rd_addr   = neuron_q;
    assign res_wr_depth = row_q;
    assign res_wr_col   = RES_COL_BITS'(neuron_q);
    assign res_wr_data  = result_q;
    assign hid_out_0    = hid0_q;
    assign hid_out_1    = hid1_q;

endmodule

// File: doc/nn_compute_sequencer.md
Name: nn_compute_sequencer

Overview:
- Sequences the two-layer inference datapath of the AXI-stream NN coprocessor once the input phase has loaded the Data RAM and the Weight RAM.
- For each dataset row it performs three dot-product passes (hidden neuron 0, hidden neuron 1, output neuron) on the external MAC unit and writes each 8-bit activation into the Result RAM.
- Sits between the top-level Compute state (start/done) and the RAMs and MAC.

Parameters:
- NUM_ROWS, 64, dataset rows processed per run
- ROW_BITS, 6, Data/Result RAM depth address width
- NUM_HIDDEN, 2, hidden neurons; the output neuron uses weight row NUM_HIDDEN
- WT_ROW_BITS, 3, Weight RAM row address width
- RES_COL_BITS, 3, Result RAM width (feature) address width
- DATA_BITS, 8, activation/result width

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous reset, active-high
- start  in  1  one-cycle request from the top FSM; honoured only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when all rows are complete
- data_rd_en  out  1  Data RAM read enable
- data_rd_addr  out  ROW_BITS  Data RAM row address
- wt_rd_en  out  1  Weight RAM read enable
- wt_rd_addr  out  WT_ROW_BITS  Weight RAM row (neuron) address
- src_sel  out  1  MAC operand select: 0 = Data RAM row, 1 = hidden vector
- hid_out_0  out  DATA_BITS  latched hidden activation 0 (MAC operand when src_sel=1)
- hid_out_1  out  DATA_BITS  latched hidden activation 1
- mac_start  out  1  one-cycle MAC start pulse
- mac_done  in  1  MAC result valid; sampled only in MAC_WAIT
- mac_result  in  DATA_BITS  activation from the MAC
- res_wr_en  out  1  Result RAM write enable
- res_wr_depth  out  ROW_BITS  Result RAM row address
- res_wr_col  out  RES_COL_BITS  Result RAM column: 0 = h0, 1 = h1, 2 = output
- res_wr_data  out  DATA_BITS  write data (registered mac_result)

Behaviour:
- Reset:
  - State goes to IDLE.
  - Every output is 0, including the row and neuron counters and hid_out_0/1.
  - Reset mid-run abandons the run without asserting done. Writes already issued are not undone.
- States: IDLE, FETCH, RD_WAIT, MAC_GO, MAC_WAIT, WRITEBACK, NEXT, FINISH.
- IDLE -> FETCH when start=1: clear row=0 and neuron=0; busy goes high the next cycle.
- FETCH:
  - Asserts wt_rd_en with wt_rd_addr=neuron.
  - Asserts data_rd_en with data_rd_addr=row only when neuron<NUM_HIDDEN.
  - src_sel = (neuron==NUM_HIDDEN).
- RD_WAIT: one cycle to cover the RAMs' 1-cycle synchronous read; read enables are low.
- MAC_GO: mac_start=1 for exactly one cycle -> MAC_WAIT.
- MAC_WAIT:
  - Holds until mac_done=1, then registers mac_result -> WRITEBACK.
  - mac_done seen in any other state is ignored.
  - No timeout.
- WRITEBACK:
  - res_wr_en=1 for one cycle, with res_wr_depth=row, res_wr_col=neuron, res_wr_data=registered result.
  - If neuron<NUM_HIDDEN, the result is also latched into hid_out_[neuron].
- NEXT:
  - If neuron<NUM_HIDDEN: neuron+1, go to FETCH.
  - Else if row==NUM_ROWS-1: go to FINISH.
  - Else: row+1, neuron=0, hid_out_0/1 hold until overwritten, go to FETCH.
  - The row counter never wraps inside a run.
- FINISH: done=1 for one cycle, busy=0 -> IDLE.
- src_sel stays stable from FETCH through WRITEBACK of a pass.
- Timing:
  - Per-pass latency is 5 + L cycles (FETCH, RD_WAIT, MAC_GO, L cycles of MAC_WAIT with L>=1, WRITEBACK, NEXT).
  - A full run takes NUM_ROWS*(NUM_HIDDEN+1) passes plus 1 cycle (FINISH).
  - Total = 192*(5+L)+1 with the defaults.
- start while busy is ignored; no queueing.
- Simultaneous start and ARESET: reset wins.

Decomposition:
- Shared package nn_pkg holds:
  - the state encoding, one-hot 8-bit, matching the top-level one-hot style
  - DATA_BITS, ROW_BITS and WT_ROW_BITS
  - the column constants COL_H0=0, COL_H1=1, COL_OUT=2
- No sub-module. The row/neuron counter pair is simple enough to stay inline.

Test Plan:
- Reset, then start with a MAC model of fixed latency L=1 that returns result = {row[4:0], neuron[2:0]}:
  - exactly 192 res_wr_en pulses
  - the last write is depth=63, col=2, data=8'hFA
  - done pulses once at cycle 192*6+1 after start
- Check the addresses and src_sel of row 5:
  - wt_rd_addr sequence is 0, 1, 2
  - data_rd_en is high only for neurons 0 and 1, with data_rd_addr=5
  - src_sel=1 only on the third pass
  - hid_out_0=8'h28 and hid_out_1=8'h29 during that pass
- MAC latency L=7, with mac_done also pulsed during FETCH and RD_WAIT:
  - the spurious pulses are ignored
  - each pass takes exactly 12 cycles
  - the result is written only after the in-state mac_done
- Assert start again at cycle 50 of a run:
  - no restart and busy unchanged
  - write count is still 192 and done pulses once
- Assert ARESET at the WRITEBACK of row 10, neuron 1:
  - the next cycle has all outputs 0 and state IDLE, with no done
  - a new start runs from row 0, col 0 to completion
- start and ARESET asserted in the same cycle: the sequencer stays IDLE and busy stays 0.
